ps2_key_tracker: RTL
====================

PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning key-event FIFO entries (power of 2, 2..64).
REQ-002 SHALL have parameter CNT_W, default 8, meaning press-counter width.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port clrn, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port byte_valid, input, 1, meaning one-cycle strobe of a received PS/2 byte.
REQ-006 SHALL have port byte_data, input, 8, meaning the scan byte, sampled only when byte_valid=1.
REQ-007 SHALL have port out_valid, output, 1, meaning the FIFO head event is valid.
REQ-008 SHALL have port out_ready, input, 1, meaning the consumer accepts the head event.
REQ-009 SHALL have port out_event, output, 17, meaning {ext, code[7:0], ascii[7:0]} of the head event.
REQ-010 SHALL have port held_valid, output, 1, meaning a key is currently held.
REQ-011 SHALL have port held_code, output, 8, meaning the scan code of the held key, 0 when none.
REQ-012 SHALL have port press_count, output, CNT_W, meaning the number of accepted press events.
REQ-013 SHALL have port overflow, output, 1, meaning sticky FIFO-drop flag.
REQ-014 SHALL have port ovf_clr, input, 1, meaning clear overflow.

Function
REQ-015 SHALL implement FSM states IDLE, HELD, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen); bytes are consumed only on byte_valid.
REQ-016 SHALL, in IDLE or HELD, go to EXT on byte 0xE0, and to BRK (HELD) or stay in IDLE on byte 0xF0.
REQ-017 SHALL treat any other byte in IDLE, or in HELD with a code different from held_code, as a press: push an event, increment press_count, set held_code, and go to HELD.
REQ-018 SHALL ignore a typematic repeat (same code while HELD): no event, no count.
REQ-019 SHALL, in BRK, on a code equal to held_code: clear held, then go to IDLE; on any other code: return to the prior state unchanged.
REQ-020 SHALL, in EXT, go to EXT_BRK on 0xF0; otherwise treat the byte as a press with ext=1 and ascii=0x00.
REQ-021 SHALL apply REQ-019 rules in EXT_BRK, matching the ext flag as well.
REQ-022 SHALL map ASCII combinationally from the set-2 code: 16,1E,26,25,2E,36,3D,3E,46,45 -> '1'..'9','0'; standard set-2 letter codes -> 'A'..'Z'; all other codes -> 0x00.
REQ-023 SHALL write an event at the clock edge that samples byte_valid; out_valid is high in the following cycle; there is no empty-FIFO bypass.
REQ-024 SHALL pop the head on an edge where out_valid&&out_ready; out_event is stable while out_valid=1 and out_ready=0.
REQ-025 SHALL, when full, drop a push and set overflow unless a pop occurs on the same edge, in which case the push is accepted.
REQ-026 SHALL give ovf_clr priority below a same-edge drop: overflow stays 1.
REQ-027 SHALL increment press_count on a dropped push, and wrap press_count modulo 2^CNT_W.
REQ-028 SHALL give held_valid=1 exactly in HELD, BRK, EXT and EXT_BRK when a key is held.

Reset
REQ-029 SHALL, while clrn=0, force FSM=IDLE, FIFO empty, out_valid=0, out_event=0, held_valid=0, held_code=0, press_count=0 and overflow=0, independent of clk.
REQ-030 SHALL discard a partial prefix sequence when reset is asserted mid-sequence; the first post-reset byte is parsed from IDLE.

Configuration
REQ-031 SHALL honour macro PS2_SHIFT_CASE_EN.
REQ-032 SHALL, with PS2_SHIFT_CASE_EN defined: track shift from presses and releases of 0x12/0x59 (no event, no count, held_code unaffected); letters are lowercase ('a'..'z') unless shift is held; shift state resets to 0.
REQ-033 SHALL, with PS2_SHIFT_CASE_EN undefined: treat 0x12/0x59 as ordinary keys (ascii 0x00) and output letters in uppercase only.

Verification
REQ-034 SHALL cover: bytes 1C,F0,1C -> one event {0,1C,41}, press_count=1, held_valid 1 then 0.
REQ-035 SHALL cover: bytes 1C,1C,1C,F0,1C -> one event only, press_count=1.
REQ-036 SHALL cover: bytes E0,75,E0,F0,75 -> event {1,75,00}, held cleared after the final byte.
REQ-037 SHALL cover: with out_ready=0, DEPTH+1 distinct presses -> DEPTH events, overflow=1, press_count=DEPTH+1; ovf_clr -> overflow=0.
REQ-038 SHALL cover: with PS2_SHIFT_CASE_EN defined, bytes 12,1C -> ascii 0x41; after F0,12 then 32 -> ascii 0x62.
REQ-039 SHALL cover: clrn pulsed low after byte E0, then byte 1C -> event {0,1C,41}, press_count=1.

Source files
------------

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: parses a PS/2 set-2 scan-byte stream into key press events.
// It tracks the currently held key, counts press events, and queues events in a
// small FIFO that signals a sticky overflow when it has to drop one.
//
// Optional macro PS2_SHIFT_CASE_EN: 0x12/0x59 become shift keys. They produce
// no events and, while shift is held, letters are uppercase. Otherwise letters
// are lowercase. Without the macro, shift codes are ordinary keys and letters
// are always uppercase.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   IDLE    | no key held, no prefix pending
//   HELD    | a key is held, no prefix pending
//   BRK     | 0xF0 seen, waiting for the released code
//   EXT     | 0xE0 seen, next byte is an extended code
//   EXT_BRK | 0xE0 0xF0 seen, waiting for the released extended code

module ps2_key_tracker #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [16:0]      out_event,
    output logic             held_valid,
    output logic [7:0]       held_code,
    output logic [CNT_W-1:0] press_count,
    output logic             overflow,
    input  logic             ovf_clr
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, HELD, BRK, EXT, EXT_BRK} state_t;

    state_t      state;
    logic        held_ext;
    logic        is_e0;
    logic        is_f0;
    logic        is_shift;
    logic        upper;
    logic        match_std;
    logic        match_ext;
    logic        press;
    logic        press_ext;
    logic [16:0] ev_data;

    logic [16:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        full;
    logic        pop;
    logic        push_ok;
    logic        drop;

`ifdef PS2_SHIFT_CASE_EN
    // A bare F0 must still be parsed as a release so that releasing shift
    // with no other key held is not mistaken for a new shift press.
    localparam bit IDLE_F0_TO_BRK = 1'b1;
    logic shift;
    assign is_shift = (byte_data == 8'h12) || (byte_data == 8'h59);
    assign upper    = shift;
`else
    localparam bit IDLE_F0_TO_BRK = 1'b0;
    assign is_shift = 1'b0;
    assign upper    = 1'b1;
`endif

    function automatic logic [7:0] ps2_ascii(input logic [7:0] code, input logic up);
        logic [7:0] a;
        case (code)
            8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
            8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;
            8'h3D: a = 8'h37;  8'h3E: a = 8'h38;  8'h46: a = 8'h39;
            8'h45: a = 8'h30;
            8'h1C: a = 8'h41;  8'h32: a = 8'h42;  8'h21: a = 8'h43;
            8'h23: a = 8'h44;  8'h24: a = 8'h45;  8'h2B: a = 8'h46;
            8'h34: a = 8'h47;  8'h33: a = 8'h48;  8'h43: a = 8'h49;
            8'h3B: a = 8'h4A;  8'h42: a = 8'h4B;  8'h4B: a = 8'h4C;
            8'h3A: a = 8'h4D;  8'h31: a = 8'h4E;  8'h44: a = 8'h4F;
            8'h4D: a = 8'h50;  8'h15: a = 8'h51;  8'h2D: a = 8'h52;
            8'h1B: a = 8'h53;  8'h2C: a = 8'h54;  8'h3C: a = 8'h55;
            8'h2A: a = 8'h56;  8'h1D: a = 8'h57;  8'h22: a = 8'h58;
            8'h35: a = 8'h59;  8'h1A: a = 8'h5A;
            default: a = 8'h00;
        endcase
        if (!up && (a >= 8'h41) && (a <= 8'h5A)) begin
            a = a | 8'h20;
        end
        return a;
    endfunction

    assign is_e0     = (byte_data == 8'hE0);
    assign is_f0     = (byte_data == 8'hF0);
    assign match_std = held_valid && !held_ext && (byte_data == held_code);
    assign match_ext = held_valid &&  held_ext && (byte_data == held_code);

    // Decode whether the current byte is a new press and build its event word.
    always_comb begin
        press     = 1'b0;
        press_ext = 1'b0;
        if (byte_valid) begin
            case (state)
                IDLE, HELD: press = !is_e0 && !is_f0 && !is_shift && !match_std;
                EXT: begin
                    press     = !is_f0 && !match_ext;
                    press_ext = 1'b1;
                end
                default: press = 1'b0;
            endcase
        end
        ev_data = {press_ext, byte_data, press_ext ? 8'h00 : ps2_ascii(byte_data, upper)};
    end

    // Prefix parser and held-key tracker.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state      <= IDLE;
            held_valid <= 1'b0;
            held_ext   <= 1'b0;
            held_code  <= 8'h00;
`ifdef PS2_SHIFT_CASE_EN
            shift      <= 1'b0;
`endif
        end else if (byte_valid) begin
            case (state)
                IDLE, HELD: begin
                    if (is_e0) begin
                        state <= EXT;
                    end else if (is_f0) begin
                        state <= (held_valid || IDLE_F0_TO_BRK) ? BRK : IDLE;
`ifdef PS2_SHIFT_CASE_EN
                    end else if (is_shift) begin
                        shift <= 1'b1;
`endif
                    end else if (press) begin
                        held_valid <= 1'b1;
                        held_ext   <= 1'b0;
                        held_code  <= byte_data;
                        state      <= HELD;
                    end
                end
                BRK: begin
                    if (match_std) begin
                        held_valid <= 1'b0;
                        held_code  <= 8'h00;
                        state      <= IDLE;
                    end else begin
`ifdef PS2_SHIFT_CASE_EN
                        if (is_shift) shift <= 1'b0;
`endif
                        state <= held_valid ? HELD : IDLE;
                    end
                end
                EXT: begin
                    if (is_f0) begin
                        state <= EXT_BRK;
                    end else begin
                        state <= HELD;
                        if (press) begin
                            held_valid <= 1'b1;
                            held_ext   <= 1'b1;
                            held_code  <= byte_data;
                        end
                    end
                end
                EXT_BRK: begin
                    if (match_ext) begin
                        held_valid <= 1'b0;
                        held_ext   <= 1'b0;
                        held_code  <= 8'h00;
                        state      <= IDLE;
                    end else begin
                        state <= held_valid ? HELD : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign out_valid = (wr_ptr != rd_ptr);
    assign pop       = out_valid && out_ready;
    assign push_ok   = press && (!full || pop);
    assign drop      = press && full && !pop;
    assign out_event = out_valid ? mem[rd_ptr[AW-1:0]] : 17'h0;

    // Event storage; contents are only visible through out_event when valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= ev_data;
        end
    end

    // FIFO pointers, press counter and sticky overflow flag.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            press_count <= '0;
            overflow    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (press)   press_count <= press_count + 1'b1;
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
